// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between R requesters and
// sends each granted message MSB-byte-first. Optional header byte: UART_ARB_HEADER_EN.
module uart_tx_arbiter #(
  parameter int N = 8,
  parameter int M = 16,
  parameter int R = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [R-1:0]   req,
  input  logic [R*M-1:0] data,
  input  logic           tx_busy,
  output logic           tx_start,
  output logic [N-1:0]   tx_data,
  output logic [R-1:0]   grant,
  output logic [R-1:0]   ack,
  output logic           active
);

  localparam int BYTES = M / N;
`ifdef UART_ARB_HEADER_EN
  localparam int FRAME = BYTES + 1;
`else
  localparam int FRAME = BYTES;
`endif
  localparam int CW = $clog2(BYTES + 2);
  localparam int IW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACC, WAIT_DONE} state_t;

  state_t        state, state_d;
  logic [M-1:0]  shift, shift_d;
  logic [CW-1:0] byte_cnt, byte_cnt_d;
  logic [IW-1:0] last, last_d;
  logic [IW-1:0] owner, owner_d;
  logic [IW-1:0] winner;
  logic          found;
  logic [N-1:0]  next_byte;
  logic          tx_start_d;
  logic [N-1:0]  tx_data_d;
  logic [R-1:0]  grant_d;
  logic [R-1:0]  ack_d;
  logic          active_d;

  // Search upward from the requester after the last owner, wrapping modulo R.
  always_comb begin
    logic [IW-1:0] cand;
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= R; k++) begin
      cand = IW'((int'(last) + k) % R);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

`ifdef UART_ARB_HEADER_EN
  logic is_header;
  assign is_header = (byte_cnt == '0);
  assign next_byte = is_header ? N'(owner) : shift[M-1 -: N];
`else
  assign next_byte = shift[M-1 -: N];
`endif

  always_comb begin
    state_d    = state;
    shift_d    = shift;
    byte_cnt_d = byte_cnt;
    last_d     = last;
    owner_d    = owner;
    tx_start_d = tx_start;
    tx_data_d  = tx_data;
    grant_d    = grant;
    ack_d      = '0;
    active_d   = active;
    case (state)
      IDLE: begin
        if (found) begin
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          owner_d         = winner;
          active_d        = 1'b1;
          shift_d         = data[winner*M +: M];
          byte_cnt_d      = '0;
          state_d         = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = next_byte;
          state_d    = WAIT_ACC;
        end
      end
      WAIT_ACC: begin
        // The header byte does not consume message bits, so the shift holds.
        if (tx_busy) begin
          tx_start_d = 1'b0;
`ifdef UART_ARB_HEADER_EN
          if (!is_header) shift_d = shift << N;
`else
          shift_d = shift << N;
`endif
          byte_cnt_d = byte_cnt + CW'(1);
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (byte_cnt == CW'(FRAME)) begin
            ack_d    = grant;
            grant_d  = '0;
            active_d = 1'b0;
            last_d   = owner;
            state_d  = IDLE;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer resets to R-1 so requester 0 wins the first arbitration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      shift    <= '0;
      byte_cnt <= '0;
      last     <= IW'(R - 1);
      owner    <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      grant    <= '0;
      ack      <= '0;
      active   <= 1'b0;
    end else begin
      state    <= state_d;
      shift    <= shift_d;
      byte_cnt <= byte_cnt_d;
      last     <= last_d;
      owner    <= owner_d;
      tx_start <= tx_start_d;
      tx_data  <= tx_data_d;
      grant    <= grant_d;
      ack      <= ack_d;
      active   <= active_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table of single messages plus
// hand-written sequences for arbitration, busy gating and mid-message reset.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] data;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        active;

  logic        model_busy = 1'b0;
  logic        force_busy;
  int          busy_cnt = 0;
  int          start_rises = 0;
  logic        prev_start = 1'b0;
  logic [7:0]  byte_log[$];

  int          passed = 0;
  int          total = 0;
  int          onehot_viol = 0;
  logic [3:0]  acks_q[$];
  logic [3:0]  grants_q[$];
  logic        ack_active;

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  idx;
    logic [15:0] msg;
    logic [3:0]  exp_grant;
    logic [7:0]  exp_hi;
    logic [7:0]  exp_lo;
    logic [3:0]  exp_ack;
  } vec_t;

  vec_t vecs[5];

  assign tx_busy = model_busy | force_busy;

  uart_tx_arbiter #(.N(8), .M(16), .R(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .data     (data),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .grant    (grant),
    .ack      (ack),
    .active   (active)
  );

  always #5 clk = ~clk;

  // TX module model: busy rises the cycle after a start and stays high 10 cycles.
  always @(negedge clk) begin
    if (!reset) begin
      busy_cnt   = 0;
      model_busy = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (tx_start && !prev_start) start_rises++;
      prev_start = tx_start;
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) model_busy = 1'b0;
      end else if (tx_start) begin
        byte_log.push_back(tx_data);
        model_busy = 1'b1;
        busy_cnt   = 10;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [3:0] r, input int idx, input logic [15:0] msg);
    for (int s = 0; s < 4; s++) data[s*16 +: 16] = 16'hC0DE ^ 16'(s);
    data[idx*16 +: 16] = msg;
    req = r;
  endtask

  task automatic applyReset();
    reset      = 1'b0;
    req        = '0;
    force_busy = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Watches grants/acks for up to budget cycles; drops a requester on its ack unless keep is set.
  task automatic runUntilAcks(input int n, input bit keep, input int budget);
    logic [3:0] prev_g;
    prev_g = grant;
    acks_q.delete();
    grants_q.delete();
    for (int cyc = 0; cyc < budget && acks_q.size() < n; cyc++) begin
      @(negedge clk);
      if ($countones(grant) > 1) onehot_viol++;
      if (grant != prev_g && grant != '0) grants_q.push_back(grant);
      prev_g = grant;
      if (ack != '0) begin
        acks_q.push_back(ack);
        ack_active = active;
        if (!keep) req = req & ~ack;
      end
    end
    if (keep) req = '0;
    checkOutput("ack_count", acks_q.size(), n);
  endtask

  task automatic checkFrame(input string name, input int base, input int sbase,
                            input logic [7:0] idx, input logic [15:0] msg);
    logic [7:0] exp_b[$];
    logic [7:0] b;
    int got;
`ifdef UART_ARB_HEADER_EN
    exp_b.push_back(idx);
`endif
    exp_b.push_back(msg[15:8]);
    exp_b.push_back(msg[7:0]);
    got = byte_log.size() - base;
    checkOutput({name, "_nbytes"}, got, exp_b.size());
    checkOutput({name, "_starts"}, start_rises - sbase, exp_b.size());
    for (int i = 0; i < exp_b.size(); i++) begin
      b = 'x;
      if (i < got) b = byte_log[base + i];
      checkOutput($sformatf("%s_byte%0d", name, i), b, exp_b[i]);
    end
  endtask

  initial begin
    int base;
    int sbase;
    bit early;
    int seen_ack;

    vecs[0] = '{4'b0001, 8'd0, 16'h4142, 4'b0001, 8'h41, 8'h42, 4'b0001};
    vecs[1] = '{4'b0100, 8'd2, 16'h4142, 4'b0100, 8'h41, 8'h42, 4'b0100};
    vecs[2] = '{4'b0010, 8'd1, 16'hA55A, 4'b0010, 8'hA5, 8'h5A, 4'b0010};
    vecs[3] = '{4'b1000, 8'd3, 16'h00FF, 4'b1000, 8'h00, 8'hFF, 4'b1000};
    vecs[4] = '{4'b0001, 8'd0, 16'hFF00, 4'b0001, 8'hFF, 8'h00, 4'b0001};

    reset      = 1'b0;
    req        = '0;
    data       = '0;
    force_busy = 1'b0;
    #1;
    checkOutput("reset_outputs", {grant, ack, active, tx_start, tx_data}, '0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("idle_after_reset", {grant, ack, active, tx_start}, '0);

    $display("[TB] vector table");
    for (int v = 0; v < 5; v++) begin
      base  = byte_log.size();
      sbase = start_rises;
      applyStimulus(vecs[v].req, int'(vecs[v].idx), vecs[v].msg);
      runUntilAcks(1, 1'b0, 400);
      checkOutput($sformatf("v%0d_grant", v), (grants_q.size() > 0) ? grants_q[0] : 4'hx, vecs[v].exp_grant);
      checkOutput($sformatf("v%0d_hi", v), vecs[v].msg[15:8], vecs[v].exp_hi);
      checkOutput($sformatf("v%0d_lo", v), vecs[v].msg[7:0], vecs[v].exp_lo);
      checkFrame($sformatf("v%0d", v), base, sbase, vecs[v].idx, vecs[v].msg);
      checkOutput($sformatf("v%0d_ack", v), (acks_q.size() > 0) ? acks_q[0] : 4'hx, vecs[v].exp_ack);
      checkOutput($sformatf("v%0d_active_at_ack", v), ack_active, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("v%0d_ack_pulse", v), ack, 4'b0000);
      checkOutput($sformatf("v%0d_active_after", v), active, 1'b0);
    end

    $display("[TB] simultaneous requests");
    applyReset();
    applyStimulus(4'b1010, 1, 16'h1234);
    data[3*16 +: 16] = 16'h5678;
    runUntilAcks(2, 1'b0, 800);
    checkOutput("simul_grant0", (grants_q.size() > 0) ? grants_q[0] : 4'hx, 4'b0010);
    checkOutput("simul_grant1", (grants_q.size() > 1) ? grants_q[1] : 4'hx, 4'b1000);
    checkOutput("simul_ack0", (acks_q.size() > 0) ? acks_q[0] : 4'hx, 4'b0010);
    checkOutput("simul_ack1", (acks_q.size() > 1) ? acks_q[1] : 4'hx, 4'b1000);

    $display("[TB] fairness");
    applyReset();
    applyStimulus(4'b1111, 0, 16'h0102);
    runUntilAcks(5, 1'b1, 2000);
    checkOutput("fair_ngrants", grants_q.size(), 5);
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("fair_grant%0d", i), (grants_q.size() > i) ? grants_q[i] : 4'hx,
                  4'b0001 << (i % 4));
    @(negedge clk);
    checkOutput("fair_idle", {grant, active}, '0);

    $display("[TB] busy gating");
    applyReset();
    force_busy = 1'b1;
    applyStimulus(4'b0001, 0, 16'h4142);
    @(negedge clk);
    checkOutput("gate_grant", grant, 4'b0001);
    checkOutput("gate_active", active, 1'b1);
    early = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx_start) early = 1'b1;
      @(negedge clk);
    end
    checkOutput("gate_no_start", early, 1'b0);
    force_busy = 1'b0;
    @(negedge clk);
    checkOutput("gate_start", tx_start, 1'b1);
`ifdef UART_ARB_HEADER_EN
    checkOutput("gate_first_byte", tx_data, 8'h00);
`else
    checkOutput("gate_first_byte", tx_data, 8'h41);
`endif
    runUntilAcks(1, 1'b0, 400);
    checkOutput("gate_ack", (acks_q.size() > 0) ? acks_q[0] : 4'hx, 4'b0001);

    $display("[TB] reset mid-message");
    applyReset();
    base = byte_log.size();
    applyStimulus(4'b0001, 0, 16'h4142);
    for (int i = 0; i < 100 && byte_log.size() == base; i++) @(negedge clk);
    checkOutput("mid_first_accept", byte_log.size() - base, 1);
    repeat (2) @(negedge clk);
    checkOutput("mid_in_progress", {active, tx_start}, 2'b10);
    #2;
    reset = 1'b0;
    req   = '0;
    #1;
    checkOutput("mid_async_reset", {grant, ack, active, tx_start, tx_data}, '0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    seen_ack = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack != '0) seen_ack++;
    end
    checkOutput("mid_no_ack", seen_ack, 0);
    base  = byte_log.size();
    sbase = start_rises;
    applyStimulus(4'b0001, 0, 16'h4142);
    runUntilAcks(1, 1'b0, 400);
    checkOutput("restart_grant", (grants_q.size() > 0) ? grants_q[0] : 4'hx, 4'b0001);
    checkFrame("restart", base, sbase, 8'd0, 16'h4142);
    checkOutput("restart_ack", (acks_q.size() > 0) ? acks_q[0] : 4'hx, 4'b0001);

    checkOutput("grant_onehot", onehot_viol, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between R requesters.
- Each requester presents an M-bit message. The block grants one requester at a time using round-robin, latches its message, and serialises it MSB-byte-first into N-bit bytes through a start/busy handshake.
- Sits between the register/sequencing logic and the UART TX module.
- Supersedes the single-source two-byte send FSM.

Parameters:
- N, 8, byte width driven to the TX module.
- M, 16, message width per requester; must be an integer multiple of N. BYTES = M/N.
- R, 4, number of requesters (2..8).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req  input  R  per-requester request level; held high until matching ack.
- data  input  R*M  requester i message at data[i*M +: M]; sampled only at grant.
- tx_busy  input  1  high while TX module is shifting a byte.
- tx_start  output  1  byte-valid to TX module (the enable); held until tx_busy seen high.
- tx_data  output  N  byte to transmit; stable while tx_start=1.
- grant  output  R  one-hot current owner; all zero when idle.
- ack  output  R  one-cycle pulse on owner's bit when its full message has finished.
- active  output  1  high from grant until the ack cycle, exclusive.

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - tx_start=0, tx_data=0, grant=0, ack=0, active=0, byte_cnt=0, shift register=0.
  - RR pointer last=R-1, so requester 0 wins first.
- States: IDLE, SEND, WAIT_ACC, WAIT_DONE.
- IDLE:
  - ack is 0 except in the cycle after completion.
  - If |req: the winner is the first set bit searching from last+1 upward, wrapping modulo R.
  - At the edge: grant<=onehot(winner), active<=1, shift<=winner's data, byte_cnt<=0, state<=SEND.
  - If no req: remain in IDLE.
- SEND:
  - If tx_busy=0: tx_start<=1, tx_data<=shift[M-1 -: N], state<=WAIT_ACC.
  - If tx_busy=1: wait; no start is ever issued while busy.
- WAIT_ACC:
  - tx_start stays high until tx_busy=1 is sampled.
  - Then: tx_start<=0, shift<=shift<<N, byte_cnt<=byte_cnt+1, state<=WAIT_DONE.
- WAIT_DONE:
  - On tx_busy=0:
    - If byte_cnt==BYTES: ack<=grant, grant<=0, active<=0, last<=winner index, state<=IDLE.
    - Otherwise: state<=SEND.
- Latency: request in IDLE with TX idle gives grant at +1 cycle and tx_start at +2 cycles.
- Arbitration is decided only in IDLE:
  - Requests arriving mid-message wait.
  - req dropping mid-message is ignored; the message completes and ack still pulses.
- Requester still high after its ack: treated as a new request. Round-robin gives every other pending requester one turn first.
- tx_data holds its last value when not starting; tx_data is don't-care when tx_start=0.
- byte_cnt width is clog2(BYTES+2); no wrap.
- Reset mid-message:
  - Immediate abort; outputs return to reset values.
  - No ack for the aborted message.
  - The pointer also resets.

Optional Feature:
- Macro UART_ARB_HEADER_EN.
- When defined:
  - Each message is preceded by one header byte = requester index zero-extended to N bits.
  - The header uses the same SEND/WAIT_ACC/WAIT_DONE sequence.
  - Completion occurs at byte_cnt==BYTES+1; frame is header, then data bytes MSB-first.
- When undefined: only the BYTES data bytes are sent; no header logic is present.

Test Plan:
- Single request: req=4'b0001, data[15:0]=16'h4142. TX model raises busy 1 cycle after start and holds it 10 cycles.
  - Expected: grant=0001; tx_data 0x41 then 0x42, each with exactly one start handshake.
  - Expected: ack=0001 for one cycle; active low afterwards.
- Simultaneous: req=4'b1010 in the same cycle.
  - Expected: requester 1 served first, then 3; acks in order 0010, 1000.
  - Expected: no overlap of grants.
- Fairness: req=4'b1111 held continuously, with acked requesters re-asserting.
  - Expected: grant sequence 0001,0010,0100,1000,0001.
- Busy gating: tx_busy=1 at the time of grant for 20 cycles.
  - Expected: tx_start stays 0 until tx_busy falls, then asserts the next cycle.
- Reset mid-message: assert reset low after the first byte is accepted.
  - Expected: outputs asynchronously go to 0; no ack.
  - Expected: after release, req=0001 restarts with byte 0x41.
- Header (UART_ARB_HEADER_EN): req=4'b0100, data=16'h4142.
  - Expected: tx_data sequence 0x02,0x41,0x42, then ack=0100.
